regfile_mp: RTL and testbench

Parametrised multi-read-port register file, the next generation of the team's single-port 8x16 memory. It provides one byte-masked write port and NR independent read ports with registered (1-cycle) read data. A built-in clear sequencer zeroes every entry after reset and on request. It serves as general storage for datapath blocks that need several operands per cycle.

---
 rtl/regfile_mp.sv | 134 +++++++++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file: one byte-masked write port, NR registered read ports,
// clear sweep after reset and on clr. Define REGFILE_MP_BYPASS_EN for write-first reads.
module regfile_mp #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NR    = 2,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               busy,
  input  logic               w_en,
  input  logic [AW-1:0]      w_addr,
  input  logic [DW-1:0]      w_data,
  input  logic [DW/8-1:0]    w_be,
  input  logic [NR-1:0]      r_en,
  input  logic [NR*AW-1:0]   r_addr,
  output logic [NR*DW-1:0]   r_data,
  output logic [NR-1:0]      r_valid
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic          busy_next;
  logic          op_ok;
  logic          wr_act;
  logic [NR-1:0] rd_act;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word [NR];

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] m;
    m = old_w;
    for (int i = 0; i < int'(BW); i++) begin
      if (be[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return m;
  endfunction

  // A clr accepted this edge also swallows any same-edge access.
  assign op_ok  = (state == IDLE) && !clr;
  assign wr_act = op_ok && w_en && in_range(w_addr);
  assign rd_act = {NR{op_ok}} & r_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      busy  <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    unique case (state)
      CLEAR: begin
        if (ptr == AW'(DEPTH - 1)) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + AW'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
    busy_next = (state_next == CLEAR);
  end

  // Storage has no reset; the sweep is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_act) begin
      mem[w_addr] <= merge(mem[w_addr], w_data, w_be);
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NR); k++) begin
      rd_word[k] = '0;
      if (in_range(r_addr[k*AW +: AW])) begin
        rd_word[k] = mem[r_addr[k*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        if (wr_act && (w_addr == r_addr[k*AW +: AW])) begin
          rd_word[k] = merge(mem[w_addr], w_data, w_be);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < int'(NR); k++) begin
        r_valid[k] <= rd_act[k];
        if (rd_act[k]) r_data[k*DW +: DW] <= rd_word[k];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default 8-entry/2-port instance and a 6-entry/1-port instance
// share stimulus and are checked every cycle against an array model plus literal checks.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        w_en;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic [1:0]  w_be;
  logic [1:0]  re;
  logic [2:0]  ra0;
  logic [2:0]  ra1;

  logic        b8;
  logic [1:0]  rv8;
  logic [31:0] rd8;
  logic        b6;
  logic [0:0]  rv6;
  logic [15:0] rd6;

  int pass_cnt;
  int total_cnt;
  int n;

  logic [15:0] m_mem [2][8];
  logic [15:0] m_rd  [2][2];
  logic        m_rv  [2][2];
  int          m_left [2];

  regfile_mp #(.DW(16), .DEPTH(8), .NR(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(b8),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .r_en(re), .r_addr({ra1, ra0}), .r_data(rd8), .r_valid(rv8)
  );

  regfile_mp #(.DW(16), .DEPTH(6), .NR(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(b6),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .r_en(re[0]), .r_addr(ra0), .r_data(rd6), .r_valid(rv6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dep(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] nw,
                                      input logic [1:0] be);
    return {be[1] ? nw[15:8] : o[15:8], be[0] ? nw[7:0] : o[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a sweep is a blackout of DEPTH edges after which storage is all zero.
  task automatic model_edge();
    logic [2:0]  ra [2];
    logic [15:0] v;
    ra[0] = ra0;
    ra[1] = ra1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_left[d] = dep(d);
        for (int a = 0; a < 8; a++) m_mem[d][a] = '0;
        for (int p = 0; p < 2; p++) begin
          m_rv[d][p] = 1'b0;
          m_rd[d][p] = '0;
        end
      end else if (m_left[d] > 0 || clr) begin
        if (m_left[d] > 0) m_left[d]--;
        else begin
          m_left[d] = dep(d);
          for (int a = 0; a < 8; a++) m_mem[d][a] = '0;
        end
        for (int p = 0; p < 2; p++) m_rv[d][p] = 1'b0;
      end else begin
        for (int p = 0; p < ((d == 0) ? 2 : 1); p++) begin
          if (re[p]) begin
            v = '0;
            if (int'(ra[p]) < dep(d)) begin
              v = m_mem[d][ra[p]];
`ifdef REGFILE_MP_BYPASS_EN
              if (w_en && w_addr == ra[p]) v = mrg(v, w_data, w_be);
`endif
            end
            m_rd[d][p] = v;
            m_rv[d][p] = 1'b1;
          end else begin
            m_rv[d][p] = 1'b0;
          end
        end
        if (w_en && int'(w_addr) < dep(d)) m_mem[d][w_addr] = mrg(m_mem[d][w_addr], w_data, w_be);
      end
    end
  endtask

  always @(posedge clk) begin
    model_edge();
    #1;
    chk("busy8", 32'(b8), 32'(m_left[0] > 0));
    chk("busy6", 32'(b6), 32'(m_left[1] > 0));
    for (int p = 0; p < 2; p++) begin
      chk("r_valid8", 32'(rv8[p]), 32'(m_rv[0][p]));
      chk("r_data8", 32'(rd8[p*16 +: 16]), 32'(m_rd[0][p]));
    end
    chk("r_valid6", 32'(rv6), 32'(m_rv[1][0]));
    chk("r_data6", 32'(rd6), 32'(m_rd[1][0]));
  end

  task automatic cyc(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [1:0] be, input logic [1:0] r, input logic [2:0] a0,
                     input logic [2:0] a1, input logic c);
    @(negedge clk);
    w_en = we; w_addr = wa; w_data = wd; w_be = be;
    re = r; ra0 = a0; ra1 = a1; clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0);
  endtask

  // Returns the edge index (1-based) at which busy8 drops, or 0 if it never does.
  task automatic count_sweep(input bit rel, input bit noisy, output int cnt);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (rel && i == 1) begin
        @(negedge clk);
        rst_n = 1'b1;
        w_en = 1'b0; re = 2'b00; clr = 1'b0;
        @(posedge clk);
        #2;
      end else if (noisy && i <= 5) begin
        cyc(1'b1, 3'd1, 16'hFFFF, 2'b11, 2'b11, 3'd1, 3'd2, 1'(i == 3));
        chk("r_valid_in_sweep", 32'(rv8), 32'd0);
      end else begin
        idle();
      end
      if (!b8) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 4; a++) begin
      cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b11, 3'(a), 3'(7 - a), 1'b0);
      chk("read_zero8", rd8, 32'h0);
      chk("read_valid8", 32'(rv8), 32'h3);
    end
  endtask

  initial begin
    logic [15:0] exp_same;
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    clr = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0;
    re = '0; ra0 = '0; ra1 = '0;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", 32'(b8), 32'd1);
    chk("reset_r_valid", 32'(rv8), 32'd0);
    chk("reset_r_data", rd8, 32'd0);

    count_sweep(1'b1, 1'b0, n);
    chk("post_reset_sweep_len", 32'(n), 32'd8);
    read_all_zero();

    // Byte-masked partial write.
    cyc(1'b1, 3'd3, 16'hBEEF, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    cyc(1'b1, 3'd3, 16'h1234, 2'b10, 2'b00, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b11, 3'd3, 3'd3, 1'b0);
    chk("byte_mask8", rd8, 32'h12EF12EF);
    chk("byte_mask6", 32'(rd6), 32'h12EF);

    // Same-edge write and dual read of one address.
    cyc(1'b1, 3'd5, 16'h1111, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    cyc(1'b1, 3'd5, 16'hA5A5, 2'b11, 2'b11, 3'd5, 3'd5, 1'b0);
`ifdef REGFILE_MP_BYPASS_EN
    exp_same = 16'hA5A5;
`else
    exp_same = 16'h1111;
`endif
    chk("same_edge_rw", rd8, {exp_same, exp_same});
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b11, 3'd5, 3'd5, 1'b0);
    chk("after_same_edge", rd8, 32'hA5A5A5A5);

    // Out-of-range address on the 6-entry instance.
    cyc(1'b1, 3'd7, 16'hFFFF, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b11, 3'd7, 3'd5, 1'b0);
    chk("oor_read6", 32'(rd6), 32'h0);
    chk("oor_valid6", 32'(rv6), 32'h1);
    chk("in_range8", rd8, 32'hA5A5FFFF);
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b01, 3'd5, 3'd0, 1'b0);
    chk("addr5_kept6", 32'(rd6), 32'hA5A5);

    // Fill, then clear with noise and a second clr during the sweep.
    for (int a = 0; a < 8; a++)
      cyc(1'b1, 3'(a), 16'(16'h1111 * (a + 1)), 2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1);
    chk("clr_busy", 32'(b8), 32'd1);
    count_sweep(1'b0, 1'b1, n);
    chk("clr_sweep_len", 32'(n), 32'd8);
    read_all_zero();

    // Reset while the sweep pointer sits at 4.
    cyc(1'b1, 3'd2, 16'h5A5A, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b11, 3'd2, 3'd2, 1'b0);
    chk("pre_reset_read", rd8, 32'h5A5A5A5A);
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1);
    repeat (4) idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midsweep_rst_data", rd8, 32'h0);
    chk("midsweep_rst_valid", 32'(rv8), 32'h0);
    chk("midsweep_rst_busy", 32'(b8), 32'h1);
    @(posedge clk);
    #2;
    count_sweep(1'b1, 1'b0, n);
    chk("rst_sweep_len", 32'(n), 32'd8);
    chk("after_rst_data", rd8, 32'h0);
    chk("after_rst_valid", 32'(rv8), 32'h0);
    cyc(1'b0, 3'd0, 16'h0, 2'b00, 2'b11, 3'd2, 3'd3, 1'b0);
    chk("after_rst_read", rd8, 32'h0);

    idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
